// File: rtl/rpn_pkg.sv
// Shared types and the ALU helper for the RPN calculator core.
//   op_t    : 4-bit command opcode
//   state_t : command sequencer states
//   err_t   : error code reported on err_code
//   rpn_result() : binary-op datapath; computed at MaxWidth, caller slices to WIDTH
package rpn_pkg;

  typedef enum logic [3:0] {
    OpPush  = 4'd0,
    OpPop   = 4'd1,
    OpAdd   = 4'd2,
    OpSub   = 4'd3,
    OpMul   = 4'd4,
    OpSll   = 4'd5,
    OpSrl   = 4'd6,
    OpSlt   = 4'd7,
    OpAnd   = 4'd8,
    OpOr    = 4'd9,
    OpNor   = 4'd10,
    OpXor   = 4'd11,
    OpSwap  = 4'd12,
    OpDup   = 4'd13,
    OpClear = 4'd14,
    OpNop   = 4'd15
  } op_t;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_t;

  typedef enum logic [1:0] {ErrNone, ErrUnderflow, ErrOverflow, ErrBadop} err_t;

  localparam int unsigned MaxWidth = 64;
  typedef logic [MaxWidth-1:0] word_t;

  // Operands arrive zero-extended; every result is correct in its low `width` bits.
  function automatic word_t rpn_result(op_t op, word_t n, word_t t, int unsigned width);
    word_t r;
    r = '0;
    case (op)
      OpAdd: r = n + t;
      OpSub: r = n - t;
      OpMul: r = n * t;
      OpSll: r = (t >= word_t'(width)) ? '0 : (n << t);
      OpSrl: r = (t >= word_t'(width)) ? '0 : (n >> t);
      OpSlt: r = (n < t) ? word_t'(1) : '0;
      OpAnd: r = n & t;
      OpOr:  r = n | t;
      OpNor: r = ~(n | t);
      OpXor: r = n ^ t;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rpn_engine_if.sv
// Command port of the RPN engine.
//   cmd_valid/cmd_ready : handshake, accepted when both high at a clock edge
//   cmd_op / cmd_val    : opcode and PUSH literal
//   done                : one-cycle completion pulse
interface rpn_engine_if #(
  parameter int unsigned WIDTH = 16
);
  import rpn_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  op_t              cmd_op;
  logic [WIDTH-1:0] cmd_val;
  logic             done;

  modport master (output cmd_valid, cmd_op, cmd_val, input cmd_ready, done);
  modport slave  (input cmd_valid, cmd_op, cmd_val, output cmd_ready, done);

endinterface

// File: rtl/rpn_stack.sv
// LIFO register file with stack pointer.
//   we_a_i/idx_a_i/data_a_i, we_b_i/idx_b_i/data_b_i : two write ports (SWAP uses both)
//   sp_load_i/sp_i : load a new stack pointer
//   sp_o           : entry count
//   top_o/next_o   : entries at sp-1 / sp-2, forced to 0 when absent
//   full_o/empty_o : sp == DEPTH / sp == 0
module rpn_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IdxW = $clog2(DEPTH),
  localparam int unsigned SpW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a_i,
  input  logic [IdxW-1:0]  idx_a_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic             we_b_i,
  input  logic [IdxW-1:0]  idx_b_i,
  input  logic [WIDTH-1:0] data_b_i,
  input  logic             sp_load_i,
  input  logic [SpW-1:0]   sp_i,
  output logic [SpW-1:0]   sp_o,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] next_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SpW-1:0]   sp_q;

  // Entries are not reset: sp gating keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[idx_a_i] <= data_a_i;
    if (we_b_i) mem_q[idx_b_i] <= data_b_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q <= '0;
    end else if (sp_load_i) begin
      sp_q <= sp_i;
    end
  end

  assign sp_o    = sp_q;
  assign top_o   = (sp_q >= SpW'(1)) ? mem_q[IdxW'(sp_q - SpW'(1))] : '0;
  assign next_o  = (sp_q >= SpW'(2)) ? mem_q[IdxW'(sp_q - SpW'(2))] : '0;
  assign full_o  = (sp_q == SpW'(DEPTH));
  assign empty_o = (sp_q == '0);

endmodule

// File: rtl/rpn_engine.sv
// RPN calculator core: IDLE -> EXEC -> WB per command.
//   clk, rst     : clock, asynchronous active-high reset
//   cmd_if       : command handshake plus done pulse
//   err_o        : sticky error flag, cleared by CLEAR
//   err_code_o   : first error since last clear
//   top_o/next_o : stack entries at sp-1 / sp-2
//   depth_o      : entry count
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned SpW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  rpn_engine_if.slave      cmd_if,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [WIDTH-1:0] top_o,
  output logic [WIDTH-1:0] next_o,
  output logic [SpW-1:0]   depth_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d, t_q, t_d, n_q, n_d, res_q, res_d;
  logic [SpW-1:0]   dep_q, dep_d;
  err_t             xerr_q, xerr_d, exec_err;
  logic             err_q, err_d;
  err_t             err_code_q, err_code_d;

  logic             we_a, we_b, sp_load, full, empty;
  logic [IdxW-1:0]  idx_a, idx_b, idx0, idx1, idx2;
  logic [WIDTH-1:0] data_a, data_b, stk_top, stk_next;
  logic [SpW-1:0]   sp, sp_new;

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .we_a_i   (we_a),
    .idx_a_i  (idx_a),
    .data_a_i (data_a),
    .we_b_i   (we_b),
    .idx_b_i  (idx_b),
    .data_b_i (data_b),
    .sp_load_i(sp_load),
    .sp_i     (sp_new),
    .sp_o     (sp),
    .top_o    (stk_top),
    .next_o   (stk_next),
    .full_o   (full),
    .empty_o  (empty)
  );

  assign idx0 = IdxW'(dep_q);
  assign idx1 = IdxW'(dep_q - SpW'(1));
  assign idx2 = IdxW'(dep_q - SpW'(2));

  // Stack is untouched between accept and WB, so full/empty still describe the latched depth.
  always_comb begin
    exec_err = ErrNone;
    case (op_q)
      OpPush:           if (full) exec_err = ErrOverflow;
      OpPop:            if (empty) exec_err = ErrUnderflow;
      OpDup: begin
        if (empty)     exec_err = ErrUnderflow;
        else if (full) exec_err = ErrOverflow;
      end
      OpClear, OpNop:   exec_err = ErrNone;
      default:          if (dep_q < SpW'(2)) exec_err = ErrUnderflow;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    val_d      = val_q;
    t_d        = t_q;
    n_d        = n_q;
    dep_d      = dep_q;
    res_d      = res_q;
    xerr_d     = xerr_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    we_a       = 1'b0;
    we_b       = 1'b0;
    idx_a      = idx0;
    idx_b      = idx2;
    data_a     = res_q;
    data_b     = t_q;
    sp_load    = 1'b0;
    sp_new     = dep_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_if.cmd_valid) begin
          op_d    = cmd_if.cmd_op;
          val_d   = cmd_if.cmd_val;
          t_d     = stk_top;
          n_d     = stk_next;
          dep_d   = sp;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = WIDTH'(rpn_result(op_q, word_t'(n_q), word_t'(t_q), WIDTH));
        xerr_d  = exec_err;
        state_d = StWb;
      end
      StWb: begin
        state_d = StIdle;
        if (xerr_q != ErrNone) begin
          err_d = 1'b1;
          if (err_code_q == ErrNone) err_code_d = xerr_q;
        end else begin
          case (op_q)
            OpPush: begin
              we_a    = 1'b1;
              data_a  = val_q;
              sp_load = 1'b1;
              sp_new  = dep_q + SpW'(1);
            end
            OpPop: begin
              sp_load = 1'b1;
              sp_new  = dep_q - SpW'(1);
            end
            OpSwap: begin
              we_a   = 1'b1;
              idx_a  = idx1;
              data_a = n_q;
              we_b   = 1'b1;
            end
            OpDup: begin
              we_a    = 1'b1;
              data_a  = t_q;
              sp_load = 1'b1;
              sp_new  = dep_q + SpW'(1);
            end
            OpClear: begin
              sp_load    = 1'b1;
              sp_new     = '0;
              err_d      = 1'b0;
              err_code_d = ErrNone;
            end
            OpNop: ;
            default: begin
              // Binary op: result replaces N, T is dropped.
              we_a    = 1'b1;
              idx_a   = idx2;
              sp_load = 1'b1;
              sp_new  = dep_q - SpW'(1);
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpNop;
      val_q      <= '0;
      t_q        <= '0;
      n_q        <= '0;
      dep_q      <= '0;
      res_q      <= '0;
      xerr_q     <= ErrNone;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      val_q      <= val_d;
      t_q        <= t_d;
      n_q        <= n_d;
      dep_q      <= dep_d;
      res_q      <= res_d;
      xerr_q     <= xerr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == StIdle);
  assign cmd_if.done      = (state_q == StWb);
  assign err_o            = err_q;
  assign err_code_o       = err_code_q;
  assign top_o            = stk_top;
  assign next_o           = stk_next;
  assign depth_o          = sp;

endmodule

// File: tb/tb_rpn_engine.sv
module tb_rpn_engine;
  import rpn_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int          Dp = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             err;
  logic [1:0]       code;
  logic [W-1:0]     top, nxt;
  logic [2:0]       depth;

  rpn_engine_if #(.WIDTH(W)) cif ();

  rpn_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_if    (cif),
    .err_o     (err),
    .err_code_o(code),
    .top_o     (top),
    .next_o    (nxt),
    .depth_o   (depth)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    op_t         op;
    logic [15:0] val;
    logic [15:0] top;
    logic [15:0] nxt;
    logic [2:0]  dep;
    logic        e;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  function automatic void av(op_t op, int val, int t, int n, int d, int e, int c);
    vec_t x;
    x.op = op; x.val = 16'(val); x.top = 16'(t); x.nxt = 16'(n);
    x.dep = 3'(d); x.e = 1'(e); x.code = 2'(c);
    vecs.push_back(x);
  endfunction

  // ---------------- reference model ----------------
  int mq[$];
  int merr, mcode;

  function automatic int calc(op_t op, int n, int t);
    longint ln, lt;
    ln = longint'(n); lt = longint'(t);
    case (op)
      OpAdd: return int'((ln + lt) & 'hFFFF);
      OpSub: return int'((ln - lt) & 'hFFFF);
      OpMul: return int'((ln * lt) & 'hFFFF);
      OpSll: return (t >= 16) ? 0 : int'((ln << t) & 'hFFFF);
      OpSrl: return (t >= 16) ? 0 : (n >> t);
      OpSlt: return (n < t) ? 1 : 0;
      OpAnd: return n & t;
      OpOr:  return n | t;
      OpNor: return (~(n | t)) & 'hFFFF;
      OpXor: return n ^ t;
      default: return 0;
    endcase
  endfunction

  task automatic model_apply(input op_t op, input int v);
    int sz, t, n, e;
    sz = mq.size();
    e  = 0;
    case (op)
      OpPush: if (sz == Dp) e = 2; else mq.push_back(v);
      OpPop:  if (sz < 1) e = 1; else void'(mq.pop_back());
      OpSwap: if (sz < 2) e = 1;
              else begin t = mq[sz-1]; mq[sz-1] = mq[sz-2]; mq[sz-2] = t; end
      OpDup:  if (sz < 1) e = 1; else if (sz == Dp) e = 2; else mq.push_back(mq[sz-1]);
      OpClear: begin mq.delete(); merr = 0; mcode = 0; end
      OpNop: ;
      default: begin
        if (sz < 2) e = 1;
        else begin
          t = mq.pop_back();
          n = mq.pop_back();
          mq.push_back(calc(op, n, t));
        end
      end
    endcase
    if (e != 0) begin
      merr = 1;
      if (mcode == 0) mcode = e;
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".top"},  32'(top),   32'((sz >= 1) ? mq[sz-1] : 0));
    chk({tag, ".next"}, 32'(nxt),   32'((sz >= 2) ? mq[sz-2] : 0));
    chk({tag, ".depth"}, 32'(depth), 32'(sz));
    chk({tag, ".err"},  32'(err),   32'(merr));
    chk({tag, ".code"}, 32'(code),  32'(mcode));
  endtask

  // Issue one command, check done lands in the WB cycle, return just after E2.
  task automatic do_cmd(input op_t op, input logic [15:0] v, input string tag);
    int n, k;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_val   = v;
    n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk({tag, ".accept"}, 32'(cif.cmd_ready), 32'd1);
      cif.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    k = 1;
    while (cif.done !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".done_lat"}, 32'(k), 32'd2);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(cif.cmd_ready), 32'd1);
  endtask

  initial begin
    int dcount;
    op_t rop;
    int  rv;

    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OpNop;
    cif.cmd_val   = '0;
    #2;
    chk("rst.ready", 32'(cif.cmd_ready), 32'd1);
    chk("rst.done",  32'(cif.done), 32'd0);
    chk("rst.err",   32'(err), 32'd0);
    chk("rst.code",  32'(code), 32'd0);
    chk("rst.top",   32'(top), 32'd0);
    chk("rst.next",  32'(nxt), 32'd0);
    chk("rst.depth", 32'(depth), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    //   op       val      top      next     d  e  code
    av(OpPush,  'h0003, 'h0003, 'h0000, 1, 0, 0);
    av(OpPush,  'h0005, 'h0005, 'h0003, 2, 0, 0);
    av(OpAdd,   0,      'h0008, 'h0000, 1, 0, 0);
    av(OpClear, 0,      0,      0,      0, 0, 0);
    av(OpPush,  'h0010, 'h0010, 'h0000, 1, 0, 0);
    av(OpPush,  'h0003, 'h0003, 'h0010, 2, 0, 0);
    av(OpSub,   0,      'h000D, 'h0000, 1, 0, 0);
    av(OpPush,  'h0002, 'h0002, 'h000D, 2, 0, 0);
    av(OpSll,   0,      'h0034, 'h0000, 1, 0, 0);
    av(OpPush,  'h0040, 'h0040, 'h0034, 2, 0, 0);
    av(OpSlt,   0,      'h0001, 'h0000, 1, 0, 0);
    av(OpClear, 0,      0,      0,      0, 0, 0);
    av(OpPush,  'h0001, 'h0001, 'h0000, 1, 0, 0);
    av(OpPush,  'h0010, 'h0010, 'h0001, 2, 0, 0);
    av(OpSrl,   0,      'h0000, 'h0000, 1, 0, 0);
    av(OpPush,  'hFFFF, 'hFFFF, 'h0000, 2, 0, 0);
    av(OpPush,  'h0002, 'h0002, 'hFFFF, 3, 0, 0);
    av(OpMul,   0,      'hFFFE, 'h0000, 2, 0, 0);
    av(OpClear, 0,      0,      0,      0, 0, 0);
    av(OpPush,  'h0001, 'h0001, 'h0000, 1, 0, 0);
    av(OpPush,  'h0002, 'h0002, 'h0001, 2, 0, 0);
    av(OpPush,  'h0003, 'h0003, 'h0002, 3, 0, 0);
    av(OpPush,  'h0004, 'h0004, 'h0003, 4, 0, 0);
    av(OpPush,  'h00AA, 'h0004, 'h0003, 4, 1, 2);
    av(OpDup,   0,      'h0004, 'h0003, 4, 1, 2);
    av(OpPop,   0,      'h0003, 'h0002, 3, 1, 2);
    av(OpPop,   0,      'h0002, 'h0001, 2, 1, 2);
    av(OpPop,   0,      'h0001, 'h0000, 1, 1, 2);
    av(OpPop,   0,      'h0000, 'h0000, 0, 1, 2);
    av(OpPop,   0,      'h0000, 'h0000, 0, 1, 2);
    av(OpClear, 0,      0,      0,      0, 0, 0);
    av(OpPush,  'h1111, 'h1111, 'h0000, 1, 0, 0);
    av(OpPush,  'h2222, 'h2222, 'h1111, 2, 0, 0);
    av(OpSwap,  0,      'h1111, 'h2222, 2, 0, 0);
    av(OpPop,   0,      'h2222, 'h0000, 1, 0, 0);
    av(OpPop,   0,      'h0000, 'h0000, 0, 0, 0);
    av(OpPop,   0,      'h0000, 'h0000, 0, 1, 1);
    av(OpNop,   0,      'h0000, 'h0000, 0, 1, 1);
    av(OpClear, 0,      0,      0,      0, 0, 0);
    av(OpPush,  'h0007, 'h0007, 'h0000, 1, 0, 0);
    av(OpDup,   0,      'h0007, 'h0007, 2, 0, 0);
    av(OpXor,   0,      'h0000, 'h0000, 1, 0, 0);
    av(OpPush,  'h00F0, 'h00F0, 'h0000, 2, 0, 0);
    av(OpNor,   0,      'hFF0F, 'h0000, 1, 0, 0);
    av(OpAdd,   0,      'hFF0F, 'h0000, 1, 1, 1);
    av(OpClear, 0,      0,      0,      0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_cmd(vecs[i].op, vecs[i].val, tag);
      chk({tag, ".top"},   32'(top),   32'(vecs[i].top));
      chk({tag, ".next"},  32'(nxt),   32'(vecs[i].nxt));
      chk({tag, ".depth"}, 32'(depth), 32'(vecs[i].dep));
      chk({tag, ".err"},   32'(err),   32'(vecs[i].e));
      chk({tag, ".code"},  32'(code),  32'(vecs[i].code));
    end

    // Underflow first so the reset below has a sticky error to clear.
    do_cmd(OpPop, 16'h0, "pre_hold");
    chk("pre_hold.err", 32'(err), 32'd1);

    // cmd_valid held through EXEC and WB: only one PUSH may be consumed.
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OpPush;
    cif.cmd_val   = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    chk("hold.ready_exec", 32'(cif.cmd_ready), 32'd0);
    @(negedge clk);
    chk("hold.done_wb", 32'(cif.done), 32'd1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("hold.depth", 32'(depth), 32'd1);
    chk("hold.top",   32'(top), 32'h55);
    repeat (4) @(negedge clk);
    chk("hold.depth_later", 32'(depth), 32'd1);

    do_cmd(OpPush, 16'h0006, "pre_rst");
    chk("pre_rst.depth", 32'(depth), 32'd2);

    // Reset during the EXEC of an ADD.
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OpAdd;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    #1;
    chk("midrst.depth", 32'(depth), 32'd0);
    chk("midrst.top",   32'(top), 32'd0);
    chk("midrst.next",  32'(nxt), 32'd0);
    chk("midrst.ready", 32'(cif.cmd_ready), 32'd1);
    chk("midrst.err",   32'(err), 32'd0);
    chk("midrst.code",  32'(code), 32'd0);
    dcount = 0;
    @(negedge clk);
    if (cif.done === 1'b1) dcount++;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cif.done !== 1'b0) dcount++;
    end
    chk("midrst.no_done", 32'(dcount), 32'd0);
    chk("midrst.depth_after", 32'(depth), 32'd0);

    // Randomized commands against the reference model.
    mq.delete();
    merr  = 0;
    mcode = 0;
    for (int i = 0; i < 300; i++) begin
      rop = op_t'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rop = OpPush;
      rv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                       : int'($urandom_range(0, 16'hFFFF));
      do_cmd(rop, 16'(rv), $sformatf("rnd%0d", i));
      model_apply(rop, rv);
      check_model($sformatf("rnd%0d.%s", i, rop.name()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
